// File: rtl/branch_predictor.sv
// Fetch-stage branch direction predictor: table of 2-bit saturating counters, plus statistics.
// Optional gshare indexing is enabled with `define BP_GSHARE_EN.
module branch_predictor #(
   parameter int unsigned ENTRIES  = 64,
   parameter int unsigned GHR_BITS = 6,
   localparam int unsigned IDX     = $clog2(ENTRIES)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [31:0]    pred_pc,
   output logic           pred_taken,
   output logic [IDX-1:0] pred_idx,
   input  logic           upd_valid,
   input  logic [IDX-1:0] upd_idx,
   input  logic           upd_pred,
   input  logic           upd_taken,
   output logic           mispredict,
   output logic [31:0]    br_count,
   output logic [31:0]    miss_count
);

   localparam logic [1:0] WEAK_NT = 2'b01;

   logic [1:0]     cnt_q [ENTRIES];
   logic [1:0]     cnt_cur;
   logic [1:0]     cnt_nxt;
   logic [IDX-1:0] pc_idx;
   logic           unused_ok;

   assign pc_idx = pred_pc[IDX+1:2];

`ifdef BP_GSHARE_EN
   logic [GHR_BITS-1:0] ghr;

   // Non-speculative history: shifts only on resolved branches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr <= '0;
      end else if (upd_valid) begin
         ghr <= {ghr[GHR_BITS-2:0], upd_taken};
      end
   end

   assign pred_idx  = pc_idx ^ IDX'(ghr);
   assign unused_ok = ^{pred_pc[1:0], pred_pc[31:IDX+2]};
`else
   assign pred_idx  = pc_idx;
   assign unused_ok = ^{pred_pc[1:0], pred_pc[31:IDX+2], 1'(GHR_BITS)};
`endif

   assign pred_taken = cnt_q[pred_idx][1];
   assign mispredict = upd_valid & (upd_pred ^ upd_taken);

   // Saturating counter step for the entry being retrained
   always_comb begin
      cnt_cur = cnt_q[upd_idx];
      cnt_nxt = cnt_cur;
      if (upd_taken) begin
         if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'd1;
      end else begin
         if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= WEAK_NT;
         end
      end else if (upd_valid) begin
         cnt_q[upd_idx] <= cnt_nxt;
      end
   end

   // Branch and misprediction counters, saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count   <= '0;
         miss_count <= '0;
      end else if (upd_valid) begin
         if (br_count != '1) br_count <= br_count + 32'd1;
         if (mispredict && (miss_count != '1)) miss_count <= miss_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (either build of BP_GSHARE_EN).
module tb_branch_predictor;

   localparam int unsigned ENTRIES = 64;
   localparam int unsigned IDX     = 6;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [31:0]    pred_pc;
   logic           pred_taken;
   logic [IDX-1:0] pred_idx;
   logic           upd_valid;
   logic [IDX-1:0] upd_idx;
   logic           upd_pred;
   logic           upd_taken;
   logic           mispredict;
   logic [31:0]    br_count;
   logic [31:0]    miss_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0]     model [ENTRIES];
   logic [IDX-1:0] ghr_m;
   logic [31:0]    br_m;
   logic [31:0]    miss_m;

   branch_predictor #(.ENTRIES(ENTRIES), .GHR_BITS(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pred_pc    (pred_pc),
      .pred_taken (pred_taken),
      .pred_idx   (pred_idx),
      .upd_valid  (upd_valid),
      .upd_idx    (upd_idx),
      .upd_pred   (upd_pred),
      .upd_taken  (upd_taken),
      .mispredict (mispredict),
      .br_count   (br_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(ENTRIES); i++) model[i] = 2'b01;
      ghr_m  = '0;
      br_m   = '0;
      miss_m = '0;
   endtask

   function automatic logic [31:0] pc_for(input logic [IDX-1:0] idx);
      logic [IDX-1:0] raw;
      raw = idx ^ ghr_m;
      return 32'({raw, 2'b00});
   endfunction

   // Expected prediction for whatever pred_pc currently holds
   function automatic logic cur_pred();
      logic [IDX-1:0] i;
      i = pred_pc[IDX+1:2] ^ ghr_m;
      return model[i][1];
   endfunction

   task automatic check_entry(input logic [IDX-1:0] idx, input string tag);
      pred_pc = pc_for(idx);
      #1;
      check({tag, "_idx"}, 32'(pred_idx), 32'(idx));
      check({tag, "_taken"}, 32'(pred_taken), 32'(model[idx][1]));
   endtask

   task automatic check_stats(input string tag);
      check({tag, "_br"}, br_count, br_m);
      check({tag, "_miss"}, miss_count, miss_m);
   endtask

   // One resolved branch; called just after a falling edge, returns on the next one
   task automatic do_update(input logic [IDX-1:0] idx, input logic taken, input string tag);
      logic pred;
      pred      = model[idx][1];
      upd_valid = 1'b1;
      upd_idx   = idx;
      upd_pred  = pred;
      upd_taken = taken;
      #1;
      check({tag, "_mispredict"}, 32'(mispredict), 32'(pred ^ taken));
      check({tag, "_rd_pre"}, 32'(pred_taken), 32'(cur_pred()));
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      if (taken && model[idx] != 2'b11) model[idx] = model[idx] + 2'd1;
      else if (!taken && model[idx] != 2'b00) model[idx] = model[idx] - 2'd1;
      br_m = br_m + 32'd1;
      if (pred ^ taken) miss_m = miss_m + 32'd1;
`ifdef BP_GSHARE_EN
      ghr_m = {ghr_m[IDX-2:0], taken};
`endif
      check({tag, "_rd_post"}, 32'(pred_taken), 32'(cur_pred()));
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      pred_pc   = 32'h0000_0040;
      upd_valid = 1'b0;
      upd_idx   = '0;
      upd_pred  = 1'b0;
      upd_taken = 1'b0;
      model_reset();
      #1;
      check("reset_taken", 32'(pred_taken), 32'd0);
      check("reset_idx", 32'(pred_idx), 32'd16);
      check_stats("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Training entry 16 toward strong-taken
      pred_pc = pc_for(16);
      do_update(16, 1'b1, "train1");
      check_entry(16, "train1_next");
      do_update(16, 1'b1, "train2");
      do_update(16, 1'b1, "train3");
      check("train3_cnt_strong", 32'(model[16]), 32'd3);
      check_stats("train3");

      // Saturation at strong-taken, then back down to weak-NT
      do_update(16, 1'b1, "sat_t");
      check_entry(16, "sat_t_next");
      do_update(16, 1'b0, "nt1");
      check_entry(16, "nt1_next");
      do_update(16, 1'b0, "nt2");
      check_entry(16, "nt2_next");
      check_stats("nt2");

      // Saturation at strong-NT on another entry
      do_update(5, 1'b0, "low1");
      do_update(5, 1'b0, "low2");
      do_update(5, 1'b1, "low3");
      check_entry(5, "low3_next");
      do_update(5, 1'b1, "low4");
      check_entry(5, "low4_next");
      check_entry(17, "untouched17");

      // Idle: ignored update fields, no state change
      upd_valid = 1'b0;
      upd_idx   = 6'd16;
      upd_pred  = 1'b1;
      upd_taken = 1'b0;
      #1;
      check("idle_mispredict", 32'(mispredict), 32'd0);
      repeat (3) @(negedge clk);
      check_entry(16, "idle16");
      check_stats("idle");

      // Same-cycle read and update of entry 16 (currently weak-NT)
      pred_pc = pc_for(16);
      #1;
      check("same_pre_state", 32'(model[16]), 32'd1);
      do_update(16, 1'b1, "same");
      check_entry(16, "same_next");
      check_stats("same");

      // Asynchronous reset between edges with an update pending
      pred_pc   = 32'h0000_0040;
      upd_valid = 1'b1;
      upd_idx   = 6'd16;
      upd_pred  = 1'b1;
      upd_taken = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_taken", 32'(pred_taken), 32'd0);
      check("arst_idx", 32'(pred_idx), 32'd16);
      check_stats("arst");
      @(posedge clk);
      #1;
      check("arst_edge_taken", 32'(pred_taken), 32'd0);
      check_stats("arst_edge");
      @(negedge clk);
      upd_valid = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      check_entry(16, "arst_after");

      // History fold: taken 1,0,1 gives ghr 000101 in the gshare build
      do_update(3, 1'b1, "ghr1");
      do_update(3, 1'b0, "ghr2");
      do_update(3, 1'b1, "ghr3");
      pred_pc = 32'h0000_0040;
      #1;
`ifdef BP_GSHARE_EN
      check("ghr_idx", 32'(pred_idx), 32'd21);
`else
      check("ghr_idx", 32'(pred_idx), 32'd16);
`endif
      check_stats("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
